// File: rtl/apb_slv_pkg.sv
// ---------------------------------------------------------------------------
// apb_slv_pkg
// Shared definitions for the apb_slv_mem APB4 completer:
//   - apb_state_e      : completer FSM state (IDLE / SETUP / ACCESS)
//   - RESP_OKAY/RESP_ERR : PSLVERR encodings
//   - strb_width()     : number of byte lanes for a data width
//   - off_width()      : number of byte-offset address bits for a data width
//   - idx_width()      : word-index width for a given depth (never below 1)
// Optional feature macro used by the design: APB_SLV_PROT_EN.
// ---------------------------------------------------------------------------
package apb_slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int off_width(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// ---------------------------------------------------------------------------
// apb_slv_regfile
// DEPTH x DATA_WIDTH flop array with per-byte write enables, synchronous
// clear and a combinational read port.
// Ports:
//   clk_i    in   clock (posedge)
//   rst_ni   in   synchronous clear, active low: every word becomes 0
//   we_i     in   write enable (qualified per lane by wstrb_i)
//   waddr_i  in   word index to write
//   wstrb_i  in   byte lane enables
//   wdata_i  in   write data
//   raddr_i  in   word index to read
//   rdata_o  out  read data (combinational)
// ---------------------------------------------------------------------------
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 6
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              we_i,
    input  logic [IDX_W-1:0]                  waddr_i,
    input  logic [strb_width(DATA_WIDTH)-1:0] wstrb_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    input  logic [IDX_W-1:0]                  raddr_i,
    output logic [DATA_WIDTH-1:0]             rdata_o
);

    localparam int NB = strb_width(DATA_WIDTH);

    // One independent byte-wide array per lane keeps each lane's write
    // enable local and avoids several processes sharing one array.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int w = 0; w < DEPTH; w++) begin
                        lane_q[w] <= 8'h00;
                    end
                end else if (we_i && wstrb_i[gi]) begin
                    lane_q[waddr_i] <= wdata_i[gi*8 +: 8];
                end
            end

            assign rdata_o[gi*8 +: 8] = lane_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/apb_slv_mem.sv
// ---------------------------------------------------------------------------
// apb_slv_mem
// Parametrised APB4 completer: byte-strobed memory array behind an APB port,
// with configurable wait states and PSLVERR responses for misaligned or
// out-of-range accesses.
// Parameters: ADDR_WIDTH, DATA_WIDTH (8/16/32/64), DEPTH, WAIT_CYCLES (0..15)
// Ports:
//   PCLK     in   clock, posedge
//   PRESETn  in   synchronous reset, active low (also clears the array)
//   PSELx    in   completer select
//   PENABLE  in   access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PSTRB    in   write byte lanes
//   PPROT    in   protection (present only with APB_SLV_PROT_EN)
//   PRDATA   out  read data, non-zero only in the PREADY cycle of a good read
//   PREADY   out  transfer complete
//   PSLVERR  out  error response, valid with PREADY
// Optional feature: define APB_SLV_PROT_EN to add PPROT; non-privileged
// accesses (PPROT[0]=0) to the upper half of the array then get PSLVERR.
// ---------------------------------------------------------------------------
module apb_slv_mem
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                              PCLK,
    input  logic                              PRESETn,
    input  logic                              PSELx,
    input  logic                              PENABLE,
    input  logic                              PWRITE,
    input  logic [ADDR_WIDTH-1:0]             PADDR,
    input  logic [DATA_WIDTH-1:0]             PWDATA,
    input  logic [strb_width(DATA_WIDTH)-1:0] PSTRB,
`ifdef APB_SLV_PROT_EN
    input  logic [2:0]                        PPROT,
`endif
    output logic [DATA_WIDTH-1:0]             PRDATA,
    output logic                              PREADY,
    output logic                              PSLVERR
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int OFFS   = off_width(DATA_WIDTH);
    localparam int IDX_W  = idx_width(DEPTH);

    // Byte-offset bits of PADDR; zero mask when the bus is one byte wide.
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((1 << OFFS) - 1);
    // One extra bit so DEPTH itself is representable even when it fills the
    // whole address space.
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_CYCLES);

    // ---------------- state ----------------
    apb_state_e              state_q;
    logic [3:0]              cnt_q;
    logic                    ready_q;
    logic                    slverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    // Request captured at the end of the setup phase.
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
`ifdef APB_SLV_PROT_EN
    localparam logic [ADDR_WIDTH:0] HALF_LIM = (ADDR_WIDTH+1)'(DEPTH / 2);
    logic                    priv_q;
    logic                    req_priv_d;
    logic                    unused_pprot;
    assign unused_pprot = ^PPROT[2:1];
`endif

    // ---------------- decode ----------------
    // In IDLE the request is still on the bus (we are looking at a setup
    // cycle); once captured, the registered copy is used so that bus changes
    // during the access phase have no effect.
    logic [ADDR_WIDTH-1:0]   req_addr_d;
    logic                    req_write_d;
    logic [ADDR_WIDTH-1:0]   req_idx_d;
    logic                    req_err_d;
    logic [DATA_WIDTH-1:0]   rf_rdata;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    commit_d;

    always_comb begin
        if (state_q == ST_IDLE) begin
            req_addr_d  = PADDR;
            req_write_d = PWRITE;
        end else begin
            req_addr_d  = addr_q;
            req_write_d = write_q;
        end
`ifdef APB_SLV_PROT_EN
        req_priv_d = (state_q == ST_IDLE) ? PPROT[0] : priv_q;
`endif
        req_idx_d = req_addr_d >> OFFS;
        req_err_d = (|(req_addr_d & OFF_MASK)) || ({1'b0, req_idx_d} >= DEPTH_LIM);
`ifdef APB_SLV_PROT_EN
        if (!req_priv_d && ({1'b0, req_idx_d} >= HALF_LIM)) begin
            req_err_d = 1'b1;
        end
`endif
        rdata_d = (!req_write_d && !req_err_d) ? rf_rdata : '0;
        // The write lands on the edge that ends the PREADY=1 cycle, provided
        // the requester is still in its access phase.
        commit_d = (state_q != ST_IDLE) && ready_q && write_q && !req_err_d
                   && PSELx && PENABLE;
    end

    apb_slv_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .we_i    (commit_d),
        .waddr_i (req_idx_d[IDX_W-1:0]),
        .wstrb_i (strb_q),
        .wdata_i (wdata_q),
        .raddr_i (req_idx_d[IDX_W-1:0]),
        .rdata_o (rf_rdata)
    );

    // ---------------- FSM + registered outputs ----------------
    // SETUP is held during the first access cycle (the request has just been
    // captured); ACCESS covers any further wait cycles. Outputs are computed
    // one edge ahead so that PREADY/PRDATA/PSLVERR are all registered.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            slverr_q <= RESP_OKAY;
            prdata_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
`ifdef APB_SLV_PROT_EN
            priv_q   <= 1'b0;
`endif
        end else begin
            ready_q  <= 1'b0;
            slverr_q <= RESP_OKAY;
            prdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    // PSELx && PENABLE without a preceding setup is ignored.
                    if (PSELx && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
`ifdef APB_SLV_PROT_EN
                        priv_q  <= PPROT[0];
`endif
                        cnt_q   <= WAIT_LOAD;
                        state_q <= ST_SETUP;
                        if (WAIT_LOAD == 4'd0) begin
                            ready_q  <= 1'b1;
                            slverr_q <= req_err_d ? RESP_ERR : RESP_OKAY;
                            prdata_q <= rdata_d;
                        end
                    end
                end
                ST_SETUP, ST_ACCESS: begin
                    if (ready_q) begin
                        state_q <= ST_IDLE;
                    end else if (!(PSELx && PENABLE)) begin
                        // Requester left the access phase early: abandon.
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            ready_q  <= 1'b1;
                            slverr_q <= req_err_d ? RESP_ERR : RESP_OKAY;
                            prdata_q <= rdata_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;
    assign PRDATA  = prdata_q;

endmodule
